exec_issue_ctrl: RTL and testbench
==================================

# exec_issue_ctrl

Issue controller in front of the execute unit. Buffers decoded operations from decode in a 2-entry FIFO and presents the head operation to the execute datapath. It captures the ALU result into a registered writeback slot and converts branch/jump outcomes (BjBus) into a one-cycle redirect pulse that flushes younger buffered operations. It sits between decode and writeback and is the only driver of the execute unit's Op/S1/S2/PC inputs.

## Interface
- BITS, 32, datapath and address width (matches execute unit)
- CNTW, 16, width of retired-operation counter

- Clk  in  1  clock, all state on rising edge
- Rst  in  1  synchronous, active-high reset
- InValid  in  1  decode offers an operation
- InReady  out  1  FIFO can accept; transfer when InValid & InReady
- InOp  in  3  operation code (001 add, 010 branch-less-than, 011 jump, 100 shift-left, 101 and)
- InS1, InS2  in  BITS  operands
- InPC  in  BITS  operation PC
- ExOp  out  3  to execute unit; 000 when FIFO empty
- ExS1, ExS2, ExPC  out  BITS  to execute unit; head entry fields, 0 when empty
- ExAluResult  in  BITS  from execute unit (combinational)
- ExBjBus  in  BITS+1  from execute unit; bit BITS = enable, low BITS = target
- OutValid  out  1  writeback slot holds a result
- OutReady  in  1  writeback consumes; transfer when OutValid & OutReady
- OutResult  out  BITS  captured ExAluResult
- OutPC  out  BITS  PC of captured operation
- RedirectValid  out  1  one-cycle pulse: fetch must restart at RedirectAddr
- RedirectAddr  out  BITS  redirect target
- RetireCount  out  CNTW  operations transferred out since reset, wraps modulo 2^CNTW

## Operation
- Storage: 2-entry FIFO of {Op, S1, S2, PC}; head drives Ex* combinationally.
- Capture: when FIFO non-empty and (OutValid==0 or OutReady==1) and state==RUN, pop head, load OutResult/OutPC, set OutValid. Otherwise hold FIFO and slot.
- Taken-redirect condition on capture: ExBjBus[BITS]==1 and (ExOp==011 or ExBjBus[BITS-1:0] != ExPC). A not-taken 010 (target == PC) retires as a normal op with no redirect.
- On a taken capture: RedirectValid=1 and RedirectAddr=ExBjBus[BITS-1:0] registered for the next cycle. The remaining FIFO entry and any operation accepted on the capture cycle are discarded. State goes to FLUSH.
- States:
  - RESET → RUN on first cycle with Rst low.
  - RUN → FLUSH on taken capture.
  - FLUSH → RUN unconditionally after 1 cycle.
- FLUSH cycle: InReady=0, no capture, RedirectValid=1.
- InReady = (count<2) in RUN. It is combinational from count only, not from OutReady.
- Simultaneous push and pop with count==2: allowed only when a pop occurs; InReady stays low whenever count==2, so no same-cycle push-on-full.
- OutValid clears on transfer unless a new capture occurs in the same cycle, in which case the slot is reloaded.
- RetireCount increments on each OutValid & OutReady.
- Arithmetic: all PC and target compares are BITS wide and unsigned; no width extension.

## Timing
- Reset values: InReady=0, OutValid=0, OutResult=0, OutPC=0, RedirectValid=0, RedirectAddr=0, RetireCount=0, Ex*=0, FIFO empty, state RESET. InReady rises the cycle after Rst falls.
- Latency: operation accepted at edge N is on Ex* during cycle N+1, captured at edge N+1, and OutValid is high in cycle N+2.
- Redirect: asserted exactly the cycle after the branch capture edge, concurrent with that branch's OutValid. Lasts exactly 1 cycle.
- Backpressure: OutReady low with a full slot stalls capture. Ex* holds stable at the head entry.
- Rst mid-operation: all entries, the slot and a pending redirect are dropped at the next edge. No redirect pulse is emitted.

## Structure
- Shared package exec_pkg holds:
  - Op code constants: OP_NOP=000, OP_ADD=001, OP_BLT=010, OP_JMP=011, OP_SHL=100, OP_AND=101.
  - State constants: RESET, RUN, FLUSH.
  - The FIFO entry struct.
- One sub-module, exec_issue_fifo: 2-entry synchronous FIFO with flush input and count output.
- Controller FSM, capture slot and counter live in exec_issue_ctrl. The execute unit is instantiated by the parent, not inside this block.

## Test plan
- Single add: push {001, 5, 7, PC=0x100} → ExOp=001 next cycle; OutValid, OutResult=12, OutPC=0x100 two cycles after push; RetireCount=1 after OutReady.
- Backpressure: OutReady=0, push 3 ops (add, and, shl) → InReady low after 2 buffered plus 1 in slot. Release OutReady → results 12, S1&S2, S1<<S2 emerge in order with no loss.
- Taken branch: push {010, S1=0x20, S2=0x30, PC=0x200} then an add → RedirectValid one cycle with RedirectAddr=0x220; the add is never output; InReady=0 in the FLUSH cycle.
- Not-taken branch: push {010, S1=0x40, S2=0x10, PC=0x300} then an add → no redirect; OutResult=0x300, then the add result.
- Jump: push {011, S1=0x8, PC=0x400} → OutResult=0x404, RedirectAddr=0x408 pulse. An op pushed in the capture cycle is discarded.
- Reset mid-flush: assert Rst during the FLUSH cycle → next cycle all outputs 0, RedirectValid=0, RetireCount=0.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the execute issue stage: opcodes, controller states
// and the buffered operation entry.
package exec_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_BLT = 3'b010;
    localparam logic [2:0] OP_JMP = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } stateT;

    typedef struct packed {
        logic [2:0]      op;
        logic [XLEN-1:0] s1;
        logic [XLEN-1:0] s2;
        logic [XLEN-1:0] pc;
    } issueEntryT;

endpackage

// File: rtl/exec_issue_fifo.sv
// Two-entry synchronous FIFO of issue entries with a flush that empties it.
// Pushes while full and pops while empty are ignored.
module exec_issue_fifo
    import exec_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Flush,
    input  logic       PushValid,
    input  issueEntryT PushData,
    input  logic       Pop,
    output issueEntryT Head,
    output logic [1:0] Count
);

    issueEntryT mem [2];
    logic       rdPtr;
    logic       wrPtr;
    logic       doPush;
    logic       doPop;

    assign doPush = PushValid && (Count != 2'd2);
    assign doPop  = Pop && (Count != 2'd0);
    assign Head   = mem[rdPtr];

    // Flush wins over a same-cycle push so a younger op cannot survive a redirect.
    always_ff @(posedge Clk) begin
        if (Rst || Flush) begin
            rdPtr <= 1'b0;
            wrPtr <= 1'b0;
            Count <= 2'd0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= PushData;
                wrPtr      <= ~wrPtr;
            end
            if (doPop) begin
                rdPtr <= ~rdPtr;
            end
            Count <= Count + {1'b0, doPush} - {1'b0, doPop};
        end
    end

endmodule

// File: rtl/exec_issue_ctrl.sv
// Issue controller: buffers decoded ops, feeds the execute unit from the FIFO
// head, captures results into a writeback slot and turns taken branches into a redirect.
module exec_issue_ctrl
    import exec_pkg::*;
#(
    parameter int BITS = XLEN,
    parameter int CNTW = 16
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            InValid,
    output logic            InReady,
    input  logic [2:0]      InOp,
    input  logic [BITS-1:0] InS1,
    input  logic [BITS-1:0] InS2,
    input  logic [BITS-1:0] InPC,
    output logic [2:0]      ExOp,
    output logic [BITS-1:0] ExS1,
    output logic [BITS-1:0] ExS2,
    output logic [BITS-1:0] ExPC,
    input  logic [BITS-1:0] ExAluResult,
    input  logic [BITS:0]   ExBjBus,
    output logic            OutValid,
    input  logic            OutReady,
    output logic [BITS-1:0] OutResult,
    output logic [BITS-1:0] OutPC,
    output logic            RedirectValid,
    output logic [BITS-1:0] RedirectAddr,
    output logic [CNTW-1:0] RetireCount,
    output stateT           DbgState
);

    stateT      state;
    issueEntryT pushEntry;
    issueEntryT headEntry;
    logic [1:0] count;
    logic       capture;
    logic       taken;
    logic       outFire;

    // Handshakes: a beat moves on a cycle where valid & ready are both high at
    // the rising edge; valid never depends on ready on either port.
    assign InReady = (state == RUN) && (count != 2'd2);
    assign outFire = OutValid && OutReady;
    assign capture = (state == RUN) && (count != 2'd0) && (!OutValid || OutReady);
    assign taken   = ExBjBus[BITS] && ((ExOp == OP_JMP) || (ExBjBus[BITS-1:0] != ExPC));
    assign DbgState = state;

    assign pushEntry = '{op: InOp, s1: InS1, s2: InS2, pc: InPC};

    always_comb begin
        ExOp = OP_NOP;
        ExS1 = '0;
        ExS2 = '0;
        ExPC = '0;
        if (count != 2'd0) begin
            ExOp = headEntry.op;
            ExS1 = headEntry.s1;
            ExS2 = headEntry.s2;
            ExPC = headEntry.pc;
        end
    end

    exec_issue_fifo u_fifo (
        .Clk       (Clk),
        .Rst       (Rst),
        .Flush     (capture && taken),
        .PushValid (InValid && InReady),
        .PushData  (pushEntry),
        .Pop       (capture),
        .Head      (headEntry),
        .Count     (count)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state         <= RESET;
            OutValid      <= 1'b0;
            OutResult     <= '0;
            OutPC         <= '0;
            RedirectValid <= 1'b0;
            RedirectAddr  <= '0;
            RetireCount   <= '0;
        end else begin
            unique case (state)
                RESET:   state <= RUN;
                RUN:     state <= (capture && taken) ? FLUSH : RUN;
                FLUSH:   state <= RUN;
                default: state <= RESET;
            endcase

            if (capture) begin
                OutValid  <= 1'b1;
                OutResult <= ExAluResult;
                OutPC     <= ExPC;
            end else if (outFire) begin
                OutValid <= 1'b0;
            end

            // Redirect is a single-cycle pulse raised alongside the branch's result.
            RedirectValid <= capture && taken;
            if (capture && taken) begin
                RedirectAddr <= ExBjBus[BITS-1:0];
            end

            if (outFire) begin
                RetireCount <= RetireCount + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_exec_issue_ctrl.sv
// Directed bench for exec_issue_ctrl with a small behavioural execute unit.
module tb_exec_issue_ctrl;
    import exec_pkg::*;

    localparam int BITS = 32;
    localparam int CNTW = 16;

    logic            Clk = 1'b0;
    logic            Rst;
    logic            InValid;
    logic            InReady;
    logic [2:0]      InOp;
    logic [BITS-1:0] InS1, InS2, InPC;
    logic [2:0]      ExOp;
    logic [BITS-1:0] ExS1, ExS2, ExPC;
    logic [BITS-1:0] ExAluResult;
    logic [BITS:0]   ExBjBus;
    logic            OutValid;
    logic            OutReady;
    logic [BITS-1:0] OutResult, OutPC;
    logic            RedirectValid;
    logic [BITS-1:0] RedirectAddr;
    logic [CNTW-1:0] RetireCount;
    stateT           DbgState;

    int compared = 0;
    int mismatched = 0;

    always #5 Clk = ~Clk;

    exec_issue_ctrl #(.BITS(BITS), .CNTW(CNTW)) dut (
        .Clk(Clk), .Rst(Rst),
        .InValid(InValid), .InReady(InReady), .InOp(InOp),
        .InS1(InS1), .InS2(InS2), .InPC(InPC),
        .ExOp(ExOp), .ExS1(ExS1), .ExS2(ExS2), .ExPC(ExPC),
        .ExAluResult(ExAluResult), .ExBjBus(ExBjBus),
        .OutValid(OutValid), .OutReady(OutReady),
        .OutResult(OutResult), .OutPC(OutPC),
        .RedirectValid(RedirectValid), .RedirectAddr(RedirectAddr),
        .RetireCount(RetireCount), .DbgState(DbgState)
    );

    // Execute unit model: BLT taken when S1<S2 (target PC+S1), else target=PC;
    // JMP links PC+4 and targets PC+S1.
    always_comb begin
        ExAluResult = '0;
        ExBjBus     = '0;
        case (ExOp)
            OP_ADD: ExAluResult = ExS1 + ExS2;
            OP_AND: ExAluResult = ExS1 & ExS2;
            OP_SHL: ExAluResult = ExS1 << ExS2[4:0];
            OP_BLT: begin
                ExAluResult = ExPC;
                ExBjBus     = {1'b1, (ExS1 < ExS2) ? (ExPC + ExS1) : ExPC};
            end
            OP_JMP: begin
                ExAluResult = ExPC + 32'd4;
                ExBjBus     = {1'b1, ExPC + ExS1};
            end
            default: ;
        endcase
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_op(input logic [2:0] op, input logic [31:0] s1,
                            input logic [31:0] s2, input logic [31:0] pc);
        InValid = 1'b1;
        InOp    = op;
        InS1    = s1;
        InS2    = s2;
        InPC    = pc;
    endtask

    task automatic drive_idle();
        InValid = 1'b0;
        InOp    = '0;
        InS1    = '0;
        InS2    = '0;
        InPC    = '0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        OutReady = 1'b0;
        drive_idle();
        tick();
        tick();
        compared++;
        if (InReady !== 1'b0 || OutValid !== 1'b0 || RedirectValid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_ctl: InReady=%b OutValid=%b RedirectValid=%b, want 0 0 0", InReady, OutValid, RedirectValid);
        end
        compared++;
        if (OutResult !== 0 || OutPC !== 0 || RedirectAddr !== 0 || RetireCount !== 0 || ExOp !== 0 || ExPC !== 0) begin
            mismatched++;
            $display("FAIL reset_data: OutResult=%h OutPC=%h RedirectAddr=%h RetireCount=%0d ExOp=%b ExPC=%h, want all 0",
                     OutResult, OutPC, RedirectAddr, RetireCount, ExOp, ExPC);
        end
        compared++;
        if (DbgState !== RESET) begin
            mismatched++;
            $display("FAIL reset_state: got %0d want %0d", DbgState, RESET);
        end
        Rst = 1'b0;
        tick();
        compared++;
        if (InReady !== 1'b1 || DbgState !== RUN) begin
            mismatched++;
            $display("FAIL reset_release: InReady=%b state=%0d, want 1 %0d", InReady, DbgState, RUN);
        end
    endtask

    task automatic test_single_add();
        OutReady = 1'b0;
        drive_op(OP_ADD, 32'd5, 32'd7, 32'h100);
        tick();
        drive_idle();
        compared++;
        if (ExOp !== OP_ADD || ExS1 !== 32'd5 || ExS2 !== 32'd7 || ExPC !== 32'h100 || OutValid !== 1'b0) begin
            mismatched++;
            $display("FAIL add_ex: ExOp=%b S1=%0d S2=%0d PC=%h OutValid=%b, want 001 5 7 100 0", ExOp, ExS1, ExS2, ExPC, OutValid);
        end
        tick();
        compared++;
        if (OutValid !== 1'b1 || OutResult !== 32'd12 || OutPC !== 32'h100 || ExOp !== OP_NOP) begin
            mismatched++;
            $display("FAIL add_out: OutValid=%b OutResult=%0d OutPC=%h ExOp=%b, want 1 12 100 000", OutValid, OutResult, OutPC, ExOp);
        end
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;
        compared++;
        if (OutValid !== 1'b0 || RetireCount !== 16'd1) begin
            mismatched++;
            $display("FAIL add_retire: OutValid=%b RetireCount=%0d, want 0 1", OutValid, RetireCount);
        end
    endtask

    task automatic test_backpressure();
        OutReady = 1'b0;
        drive_op(OP_ADD, 32'd5, 32'd7, 32'h110);
        tick();
        drive_op(OP_AND, 32'hF0, 32'h3C, 32'h114);
        tick();
        drive_op(OP_SHL, 32'd3, 32'd5, 32'h118);
        tick();
        drive_idle();
        compared++;
        if (InReady !== 1'b0 || OutValid !== 1'b1 || OutResult !== 32'd12 || ExOp !== OP_AND) begin
            mismatched++;
            $display("FAIL bp_full: InReady=%b OutValid=%b OutResult=%0d ExOp=%b, want 0 1 12 101", InReady, OutValid, OutResult, ExOp);
        end
        tick();
        compared++;
        if (ExOp !== OP_AND || ExS1 !== 32'hF0 || ExPC !== 32'h114 || OutResult !== 32'd12 || InReady !== 1'b0) begin
            mismatched++;
            $display("FAIL bp_hold: ExOp=%b ExS1=%h ExPC=%h OutResult=%0d InReady=%b, want 101 f0 114 12 0",
                     ExOp, ExS1, ExPC, OutResult, InReady);
        end
        OutReady = 1'b1;
        tick();
        compared++;
        if (OutValid !== 1'b1 || OutResult !== 32'h30 || OutPC !== 32'h114 || InReady !== 1'b1) begin
            mismatched++;
            $display("FAIL bp_and: OutValid=%b OutResult=%h OutPC=%h InReady=%b, want 1 30 114 1", OutValid, OutResult, OutPC, InReady);
        end
        tick();
        compared++;
        if (OutValid !== 1'b1 || OutResult !== 32'h60 || OutPC !== 32'h118) begin
            mismatched++;
            $display("FAIL bp_shl: OutValid=%b OutResult=%h OutPC=%h, want 1 60 118", OutValid, OutResult, OutPC);
        end
        tick();
        compared++;
        if (OutValid !== 1'b0 || RetireCount !== 16'd4) begin
            mismatched++;
            $display("FAIL bp_retire: OutValid=%b RetireCount=%0d, want 0 4", OutValid, RetireCount);
        end
    endtask

    task automatic test_taken_branch();
        OutReady = 1'b1;
        drive_op(OP_BLT, 32'h20, 32'h30, 32'h200);
        tick();
        drive_op(OP_ADD, 32'd1, 32'd2, 32'h204);
        tick();
        drive_idle();
        compared++;
        if (RedirectValid !== 1'b1 || RedirectAddr !== 32'h220 || OutValid !== 1'b1 || OutPC !== 32'h200) begin
            mismatched++;
            $display("FAIL br_redirect: RedirectValid=%b RedirectAddr=%h OutValid=%b OutPC=%h, want 1 220 1 200",
                     RedirectValid, RedirectAddr, OutValid, OutPC);
        end
        compared++;
        if (InReady !== 1'b0 || ExOp !== OP_NOP || DbgState !== FLUSH) begin
            mismatched++;
            $display("FAIL br_flush: InReady=%b ExOp=%b state=%0d, want 0 000 %0d", InReady, ExOp, DbgState, FLUSH);
        end
        tick();
        compared++;
        if (RedirectValid !== 1'b0 || InReady !== 1'b1 || OutValid !== 1'b0 || ExOp !== OP_NOP) begin
            mismatched++;
            $display("FAIL br_after: RedirectValid=%b InReady=%b OutValid=%b ExOp=%b, want 0 1 0 000",
                     RedirectValid, InReady, OutValid, ExOp);
        end
        tick();
        compared++;
        if (OutValid !== 1'b0 || RetireCount !== 16'd5) begin
            mismatched++;
            $display("FAIL br_dropped: OutValid=%b RetireCount=%0d, want 0 5", OutValid, RetireCount);
        end
    endtask

    task automatic test_not_taken();
        OutReady = 1'b1;
        drive_op(OP_BLT, 32'h40, 32'h10, 32'h300);
        tick();
        drive_op(OP_ADD, 32'd2, 32'd3, 32'h304);
        tick();
        drive_idle();
        compared++;
        if (RedirectValid !== 1'b0 || OutValid !== 1'b1 || OutResult !== 32'h300 || ExOp !== OP_ADD) begin
            mismatched++;
            $display("FAIL nt_branch: RedirectValid=%b OutValid=%b OutResult=%h ExOp=%b, want 0 1 300 001",
                     RedirectValid, OutValid, OutResult, ExOp);
        end
        tick();
        compared++;
        if (RedirectValid !== 1'b0 || OutValid !== 1'b1 || OutResult !== 32'd5 || OutPC !== 32'h304) begin
            mismatched++;
            $display("FAIL nt_add: RedirectValid=%b OutValid=%b OutResult=%0d OutPC=%h, want 0 1 5 304",
                     RedirectValid, OutValid, OutResult, OutPC);
        end
        tick();
        compared++;
        if (OutValid !== 1'b0 || RetireCount !== 16'd7) begin
            mismatched++;
            $display("FAIL nt_retire: OutValid=%b RetireCount=%0d, want 0 7", OutValid, RetireCount);
        end
    endtask

    task automatic test_jump();
        OutReady = 1'b1;
        drive_op(OP_JMP, 32'h8, 32'h0, 32'h400);
        tick();
        drive_op(OP_ADD, 32'd4, 32'd4, 32'h404);
        tick();
        drive_idle();
        compared++;
        if (OutResult !== 32'h404 || RedirectValid !== 1'b1 || RedirectAddr !== 32'h408 || InReady !== 1'b0) begin
            mismatched++;
            $display("FAIL jmp_out: OutResult=%h RedirectValid=%b RedirectAddr=%h InReady=%b, want 404 1 408 0",
                     OutResult, RedirectValid, RedirectAddr, InReady);
        end
        tick();
        compared++;
        if (RedirectValid !== 1'b0 || OutValid !== 1'b0 || ExOp !== OP_NOP || RetireCount !== 16'd8) begin
            mismatched++;
            $display("FAIL jmp_after: RedirectValid=%b OutValid=%b ExOp=%b RetireCount=%0d, want 0 0 000 8",
                     RedirectValid, OutValid, ExOp, RetireCount);
        end
    endtask

    task automatic test_reset_mid_flush();
        OutReady = 1'b1;
        drive_op(OP_JMP, 32'h10, 32'h0, 32'h500);
        tick();
        drive_idle();
        tick();
        compared++;
        if (RedirectValid !== 1'b1 || RedirectAddr !== 32'h510) begin
            mismatched++;
            $display("FAIL rst_pre: RedirectValid=%b RedirectAddr=%h, want 1 510", RedirectValid, RedirectAddr);
        end
        Rst = 1'b1;
        tick();
        compared++;
        if (OutValid !== 1'b0 || OutResult !== 0 || OutPC !== 0 || RedirectValid !== 1'b0 ||
            RedirectAddr !== 0 || RetireCount !== 0 || InReady !== 1'b0 || ExOp !== 0) begin
            mismatched++;
            $display("FAIL rst_flush: OutValid=%b OutResult=%h OutPC=%h RedirectValid=%b RedirectAddr=%h RetireCount=%0d InReady=%b ExOp=%b, want all 0",
                     OutValid, OutResult, OutPC, RedirectValid, RedirectAddr, RetireCount, InReady, ExOp);
        end
        Rst = 1'b0;
        tick();
        tick();
        compared++;
        if (InReady !== 1'b1 || RedirectValid !== 1'b0 || OutValid !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_recover: InReady=%b RedirectValid=%b OutValid=%b, want 1 0 0", InReady, RedirectValid, OutValid);
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_backpressure();
        test_taken_branch();
        test_not_taken();
        test_jump();
        test_reset_mid_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
